// File: rtl/arb4_ctrl.sv
// Four-requester arbiter with a hold-time limit; fixed priority 3>2>1>0 by default,
// round-robin selection when ARB4_ROUND_ROBIN_EN is defined.
module arb4_ctrl #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  // state | meaning
  // IDLE  | no owner; grants when en=1 and any req is set
  // BUSY  | one owner holds gnt until done, req drop, or hold limit
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

  state_t           r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_gnt_id;
  logic             r_gnt_valid;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_win_id;

`ifdef ARB4_ROUND_ROBIN_EN
  logic [1:0] r_last;
  logic [1:0] w_idx;
  logic       w_found;

  // Search last-1, last-2, last-3, last; first asserted requester wins.
  always_comb begin
    w_win_id = 2'd0;
    w_idx    = 2'd0;
    w_found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last - 2'(i);
      if (!w_found && req[w_idx]) begin
        w_win_id = w_idx;
        w_found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_win_id = 2'd0;
    if (req[3])      w_win_id = 2'd3;
    else if (req[2]) w_win_id = 2'd2;
    else if (req[1]) w_win_id = 2'd1;
    else             w_win_id = 2'd0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= 4'b0000;
      r_gnt_id    <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
`ifdef ARB4_ROUND_ROBIN_EN
      r_last      <= 2'd0;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && (req != 4'b0000)) begin
            r_state     <= S_BUSY;
            r_gnt       <= 4'b0001 << w_win_id;
            r_gnt_id    <= w_win_id;
            r_gnt_valid <= 1'b1;
            r_cnt       <= '0;
`ifdef ARB4_ROUND_ROBIN_EN
            r_last      <= w_win_id;
`endif
          end else begin
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
          end
        end
        S_BUSY: begin
          // done outranks the hold limit, so a coincident done suppresses timeout
          if (done || !req[r_gnt_id] || (r_cnt == MAX_CNT)) begin
            r_state     <= S_IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= !done && req[r_gnt_id];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= 4'b0000;
          r_gnt_id    <= 2'd0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_arb4_ctrl.sv
// Directed bench for arb4_ctrl (default MAX_HOLD=15); round-robin expectations
// are selected when ARB4_ROUND_ROBIN_EN is defined.
module tb_arb4_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_pass;
  int n_total;

  arb4_ctrl #(.MAX_HOLD(15), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                         input logic e_valid, input logic e_to);
    chk({tag, ".gnt"}, {4'd0, gnt}, {4'd0, e_gnt});
    chk({tag, ".gnt_id"}, {6'd0, gnt_id}, {6'd0, e_id});
    chk({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, e_valid});
    chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, e_to});
  endtask

  task automatic reset_dut();
    rst  = 1'b1;
    en   = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] rr_seq [5];

  initial begin
    n_pass  = 0;
    n_total = 0;

    // reset state
    reset_dut();
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // basic grant, done release, regrant after dead cycle
    en  = 1'b1;
    req = 4'b1010;
    tick();
    chk_out("grant_a", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("done_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
`ifdef ARB4_ROUND_ROBIN_EN
    chk_out("regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
    chk_out("regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
`endif

    // en gating; en drop in BUSY keeps owner
    reset_dut();
    en  = 1'b0;
    req = 4'b1111;
    tick();
    tick();
    chk_out("en_off", 4'b0000, 2'd0, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    chk_out("en_on", 4'b1000, 2'd3, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    tick();
    chk_out("en_drop_busy", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("en_drop_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_out("en_off_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // forced release after MAX_HOLD+1 grant cycles
    reset_dut();
    en  = 1'b1;
    req = 4'b0010;
    tick();
    chk_out("hold_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("hold_gnt", {4'd0, gnt}, 8'h02);
      chk("hold_to", {7'd0, timeout}, 8'h00);
    end
    tick();
    chk_out("timeout_rel", 4'b0000, 2'd0, 1'b0, 1'b1);
    en = 1'b0;
    tick();
    chk_out("timeout_pulse_end", 4'b0000, 2'd0, 1'b0, 1'b0);

    // owner drops req while others remain
    reset_dut();
    en  = 1'b1;
    req = 4'b1111;
    tick();
    chk_out("drop_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0111;
    tick();
    chk_out("drop_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_out("drop_next", 4'b0100, 2'd2, 1'b1, 1'b0);

    // done coincident with hold limit: no timeout
    reset_dut();
    en  = 1'b1;
    req = 4'b0010;
    tick();
    chk_out("dl_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk_out("dl_at_max", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    en   = 1'b0;
    chk_out("dl_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_out("dl_after", 4'b0000, 2'd0, 1'b0, 1'b0);

    // reset mid-BUSY
    en  = 1'b1;
    req = 4'b0100;
    tick();
    chk_out("rst_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    tick();
    rst  = 1'b1;
    done = 1'b1;
    tick();
    chk_out("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst  = 1'b0;
    done = 1'b0;

    // grant sequence with all requesters held
`ifdef ARB4_ROUND_ROBIN_EN
    rr_seq[0] = 2'd3; rr_seq[1] = 2'd2; rr_seq[2] = 2'd1; rr_seq[3] = 2'd0; rr_seq[4] = 2'd3;
`else
    rr_seq[0] = 2'd3; rr_seq[1] = 2'd3; rr_seq[2] = 2'd3; rr_seq[3] = 2'd3; rr_seq[4] = 2'd3;
`endif
    reset_dut();
    en  = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("seq_id", {6'd0, gnt_id}, {6'd0, rr_seq[k]});
      chk("seq_gnt", {4'd0, gnt}, {4'd0, 4'b0001 << rr_seq[k]});
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("seq_rel", {7'd0, gnt_valid}, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arb4_ctrl.md
# arb4_ctrl

Four-requester arbiter and sequencer for the shared 2-bit priority-encoded grant path. Samples four request lines, selects one owner by priority, holds a registered one-hot grant plus its 2-bit encoded index until the owner signals completion, then returns to idle. A hold-time counter forcibly reclaims the resource from an owner that never finishes.

## Interface
- `MAX_HOLD`, default 15: maximum number of BUSY cycles after the grant cycle before a forced release; legal range 1..2^CNT_W−1.
- `CNT_W`, default 4: width of the hold counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: arbitration enable; gates new grants only.
- `req` in 4: request lines; `req[3]` is requester 3.
- `done` in 1: owner's completion strobe, single cycle, meaningful only in BUSY.
- `gnt` out 4: one-hot grant, registered.
- `gnt_id` out 2: encoded index of the granted requester, registered; 0 when `gnt_valid` is low.
- `gnt_valid` out 1: high whenever `gnt` is non-zero.
- `timeout` out 1: one-cycle pulse on a forced release.

## Operation
- States: IDLE, BUSY.
- Reset: state IDLE; `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0, hold counter 0, RR pointer 0.
- IDLE: if `en`=1 and `req`≠0, select a winner, load `gnt`/`gnt_id`, set `gnt_valid`, clear the hold counter, go to BUSY. Otherwise stay in IDLE with all outputs 0.
- BUSY, release conditions in priority order:
  - `done`=1: release.
  - The owner's `req` bit is 0: release.
  - Hold counter == `MAX_HOLD`: release and pulse `timeout`.
  - Otherwise: increment the hold counter and keep the grant.
- Release means the next state is IDLE and `gnt`, `gnt_id` and `gnt_valid` go to 0.
- Requests from non-owners are ignored in BUSY. The grant never changes hands without passing through IDLE.
- `en`=0 in BUSY does not abort the current owner.
- Fixed priority (default): 3 > 2 > 1 > 0.
- Hold counter is CNT_W bits and never wraps, because release occurs at `MAX_HOLD`.

## Timing
- Grant latency: `req` sampled at edge k in IDLE; `gnt` is valid after edge k.
- Release: `done` sampled at edge m; `gnt`=0 after edge m. The earliest next grant appears after edge m+1, so there is exactly one dead cycle between owners.
- A grant lasts at most `MAX_HOLD`+1 cycles. `timeout` is high for exactly the first IDLE cycle after a forced release.
- `done` and timeout on the same cycle: `done` wins and there is no `timeout` pulse.
- `rst` mid-BUSY: at the next edge all outputs are 0 and the state is IDLE, regardless of `done`, `req` or the counter.

## Configuration
- Macro `ARB4_ROUND_ROBIN_EN`.
- Undefined: fixed priority 3 > 2 > 1 > 0.
- Defined: round-robin selection.
  - A 2-bit pointer `last` holds the ID of the most recent grant; reset value 0.
  - Search order is `last`−1, `last`−2, `last`−3, `last` (all mod 4), and the first requester asserted in that order wins.
  - `last` updates on every grant.
  - With reset value 0 the first search order is 3,2,1,0, identical to fixed priority.

## Test plan
- Reset, then `req`=4'b1010 with `en`=1: one cycle later `gnt`=4'b1000, `gnt_id`=3, `gnt_valid`=1. `done` pulse: next cycle all outputs are 0. With `req` still 4'b1010, the following cycle `gnt`=4'b1000 again (fixed) or 4'b0010 (RR).
- `en`=0 with `req`=4'b1111: outputs stay 0. Raise `en`: grant to requester 3. Drop `en` during BUSY: the grant persists until `done`.
- Grant to 1 (`req`=4'b0010), hold `req`, no `done`, `MAX_HOLD`=15: `gnt` is high for 16 cycles, then `gnt`=0 with `timeout`=1 for one cycle.
- In BUSY, drop the owner's `req` while other requesters stay asserted: release the next cycle, with no `timeout`.
- `done` on the same cycle the counter reaches `MAX_HOLD`: release with `timeout`=0. Assert `rst` mid-BUSY: all outputs 0 one edge later.
- RR build, `req`=4'b1111 held, `done` one cycle after each grant: grant sequence is 3,2,1,0,3.
